// File: rtl/m_cache_ctrl.sv
// Miss-handling and write-through controller for the 8-set direct-mapped M-stage data cache.
// Stalls on load misses, refills from data memory, writes stores through, counts load hits/misses.
module m_cache_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             store_i,
    input  logic             byte_i,
    input  logic             unsigned_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             cache_hit_i,
    input  logic [31:0]      cache_rdata_i,
    output logic [2:0]       cache_op_o,
    output logic             cache_fill_o,
    output logic [31:0]      cache_wdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_byte_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StFill,
        StWrite
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fill_q, fill_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic       load_req;
    logic       store_req;
    logic [2:0] load_op;
    logic [2:0] store_op;

    assign load_req  = req_i & ~store_i;
    assign store_req = req_i & store_i;
    // op[2] = unsigned byte, op[1] = byte, op[0] = store
    assign load_op   = {byte_i & unsigned_i, byte_i, 1'b0};
    assign store_op  = {1'b0, byte_i, 1'b1};

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        cache_op_o    = 3'b000;
        cache_fill_o  = 1'b0;
        cache_wdata_o = 32'h0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_byte_o    = 1'b0;
        mem_addr_o    = 32'h0;
        mem_wdata_o   = 32'h0;
        stall_o       = 1'b0;
        rdata_o       = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    if (cache_hit_i) begin
                        cache_op_o = load_op;
                        rdata_o    = cache_rdata_i;
                        hit_cnt_d  = hit_cnt_q + CNT_W'(1);
                    end else begin
                        stall_o    = 1'b1;
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        state_d    = StRefill;
                    end
                end else if (store_req) begin
                    // Cache stays untouched until memory acknowledges the write.
                    stall_o = 1'b1;
                    state_d = StWrite;
                end
            end

            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_i[31:2], 2'b00};
                stall_o    = 1'b1;
                if (mem_ack_i) begin
                    fill_d  = mem_rdata_i;
                    state_d = StFill;
                end
            end

            StFill: begin
                cache_fill_o  = 1'b1;
                cache_wdata_o = fill_q;
                stall_o       = 1'b1;
                state_d       = StIdle;
            end

            StWrite: begin
                mem_req_o     = 1'b1;
                mem_we_o      = 1'b1;
                mem_byte_o    = byte_i;
                mem_addr_o    = addr_i;
                mem_wdata_o   = wdata_i;
                cache_wdata_o = wdata_i;
                stall_o       = ~mem_ack_i;
                if (mem_ack_i) begin
                    // No write-allocate: only update a line that is already resident.
                    if (cache_hit_i) begin
                        cache_op_o = store_op;
                    end
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fill_q     <= 32'h0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_m_cache_ctrl.sv
// Bench for m_cache_ctrl: models the cache array and data memory around the controller,
// runs directed vectors, corner sequences and random accesses against a reference model.
module tb_m_cache_ctrl;

    bit          clk;
    logic        rst;
    logic        req_i, store_i, byte_i, unsigned_i;
    logic [31:0] addr_i, wdata_i;
    logic        cache_hit_i;
    logic [31:0] cache_rdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    logic [2:0]  cache_op_o;
    logic        cache_fill_o;
    logic [31:0] cache_wdata_o;
    logic        mem_req_o, mem_we_o, mem_byte_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic [15:0] hit_cnt_o, miss_cnt_o;

    logic [2:0]  op2;
    logic        fill2, mreq2, mwe2, mbyte2, stall2;
    logic [31:0] cwd2, maddr2, mwd2, rdata2;
    logic [1:0]  hit_cnt2, miss_cnt2;

    always #5 clk = ~clk;

    m_cache_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .store_i(store_i), .byte_i(byte_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .cache_hit_i(cache_hit_i), .cache_rdata_i(cache_rdata_i),
        .cache_op_o(cache_op_o), .cache_fill_o(cache_fill_o), .cache_wdata_o(cache_wdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    // Narrow-counter twin sees identical inputs, so it tracks the main DUT modulo 4.
    m_cache_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_i(req_i), .store_i(store_i), .byte_i(byte_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .cache_hit_i(cache_hit_i), .cache_rdata_i(cache_rdata_i),
        .cache_op_o(op2), .cache_fill_o(fill2), .cache_wdata_o(cwd2),
        .mem_req_o(mreq2), .mem_we_o(mwe2), .mem_byte_o(mbyte2),
        .mem_addr_o(maddr2), .mem_wdata_o(mwd2), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall2), .rdata_o(rdata2),
        .hit_cnt_o(hit_cnt2), .miss_cnt_o(miss_cnt2)
    );

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic byt, input logic uns,
                                        input logic [1:0] off);
        logic [31:0] b;
        if (!byt) return w;
        b = (w >> (32'(off) * 8)) & 32'hFF;
        if (uns || b < 32'h80) return b;
        return b | 32'hFFFF_FF00;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
        int unsigned sh;
        sh = 32'(off) * 8;
        return (w & ~(32'hFF << sh)) | (32'(b) << sh);
    endfunction

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    // Cache array seen by the controller; written on the negedge like the real one.
    bit        c_valid [8];
    bit [26:0] c_tag   [8];
    bit [31:0] c_data  [8];

    always_comb begin
        cache_hit_i   = c_valid[addr_i[4:2]] && (c_tag[addr_i[4:2]] == addr_i[31:5]);
        cache_rdata_i = fmt(c_data[addr_i[4:2]], byte_i, unsigned_i, addr_i[1:0]);
    end

    always @(negedge clk) begin
        if (cache_fill_o || cache_op_o == 3'b001) begin
            c_valid[addr_i[4:2]] <= 1'b1;
            c_tag[addr_i[4:2]]   <= addr_i[31:5];
            c_data[addr_i[4:2]]  <= cache_wdata_o;
        end else if (cache_op_o == 3'b011) begin
            c_valid[addr_i[4:2]] <= 1'b1;
            c_tag[addr_i[4:2]]   <= addr_i[31:5];
            c_data[addr_i[4:2]]  <= put_byte(c_data[addr_i[4:2]], addr_i[1:0], cache_wdata_o[7:0]);
        end
    end

    // Data memory contents as the bench's memory responder sees them.
    logic [31:0] env_mem [int unsigned];

    function automatic logic [31:0] env_read(input logic [31:0] a);
        if (env_mem.exists(a[31:2])) return env_mem[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    // Reference model: memory image, resident line per set, load counters.
    logic [31:0] ref_mem [int unsigned];
    int          ref_res [8];
    int          ref_hits, ref_misses;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        int          stalls;
        int          fills;
        int          reqs;
        logic [2:0]  op;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        mwe;
        logic        mbyte;
    } exp_t;

    function automatic exp_t ref_apply(input logic st, input logic byt, input logic uns,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input int lat);
        exp_t        e;
        int          set;
        int          tg;
        bit          hit;
        logic [31:0] w;
        set = int'(a[4:2]);
        tg  = int'(a[31:5]);
        hit = (ref_res[set] == tg);
        w   = ref_read(a);
        e.fills = 0;
        if (st) begin
            e.rdata  = 32'h0;
            e.stalls = lat + 1;
            e.reqs   = lat + 1;
            e.op     = hit ? (byt ? 3'b011 : 3'b001) : 3'b000;
            e.maddr  = a;
            e.mwdata = wd;
            e.mwe    = 1'b1;
            e.mbyte  = byt;
            ref_mem[a[31:2]] = byt ? put_byte(w, a[1:0], wd[7:0]) : wd;
        end else begin
            e.rdata  = fmt(w, byt, uns, a[1:0]);
            e.op     = byt ? (uns ? 3'b110 : 3'b010) : 3'b000;
            e.maddr  = a & ~32'h3;
            e.mwdata = 32'h0;
            e.mwe    = 1'b0;
            e.mbyte  = 1'b0;
            if (hit) begin
                e.stalls = 0;
                e.reqs   = 0;
            end else begin
                e.stalls = lat + 3;
                e.reqs   = lat + 1;
                e.fills  = 1;
                ref_misses++;
                ref_res[set] = tg;
            end
            ref_hits++;
        end
        return e;
    endfunction

    int n_cmp, n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          stalls;
        int          fills;
        int          reqs;
        logic [2:0]  op;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        mwe;
        logic        mbyte;
        int          hold_bad;
        int          op_bad;
        bit          done;
    } res_t;

    // Holds the request until a cycle without stall; acts as memory with `lat` wait cycles.
    task automatic do_access(input logic st, input logic byt, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input int lat,
                             output res_t r);
        r = '{rdata: 32'h0, stalls: 0, fills: 0, reqs: 0, op: 3'b000, maddr: 32'h0,
              mwdata: 32'h0, mwe: 1'b0, mbyte: 1'b0, hold_bad: 0, op_bad: 0, done: 1'b0};
        req_i = 1'b1; store_i = st; byte_i = byt; unsigned_i = uns; addr_i = a; wdata_i = wd;
        for (int cyc = 0; cyc < 60 && !r.done; cyc++) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (mem_req_o && r.reqs == lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = env_read(mem_addr_o);
            end
            #2;
            if (mem_req_o) begin
                if (r.reqs == 0) begin
                    r.maddr = mem_addr_o; r.mwdata = mem_wdata_o;
                    r.mwe = mem_we_o; r.mbyte = mem_byte_o;
                end else if (mem_addr_o !== r.maddr || mem_wdata_o !== r.mwdata ||
                             mem_we_o !== r.mwe || mem_byte_o !== r.mbyte) begin
                    r.hold_bad++;
                end
                if (mem_ack_i && mem_we_o) begin
                    env_mem[mem_addr_o[31:2]] = mem_byte_o ?
                        put_byte(env_read(mem_addr_o), mem_addr_o[1:0], mem_wdata_o[7:0]) :
                        mem_wdata_o;
                end
                r.reqs++;
            end
            if (cache_fill_o) r.fills++;
            if (stall_o) begin
                r.stalls++;
                if (cache_op_o != 3'b000) r.op_bad++;
            end else begin
                r.done  = 1'b1;
                r.rdata = rdata_o;
                r.op    = cache_op_o;
            end
            step();
        end
        req_i = 1'b0; store_i = 1'b0; byte_i = 1'b0; unsigned_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic compare(input string tag, input res_t r, input exp_t e, input bit chk_rd);
        check({tag, " done"}, 32'(r.done), 32'd1);
        if (!r.done) return;
        check({tag, " stalls"}, r.stalls, e.stalls);
        check({tag, " fills"}, r.fills, e.fills);
        check({tag, " mem reqs"}, r.reqs, e.reqs);
        check({tag, " op"}, 32'(r.op), 32'(e.op));
        check({tag, " op during stall"}, r.op_bad, 0);
        if (chk_rd) check({tag, " rdata"}, r.rdata, e.rdata);
        if (e.reqs > 0) begin
            check({tag, " mem_addr"}, r.maddr, e.maddr);
            check({tag, " mem_we/byte"}, {r.mwe, r.mbyte}, {e.mwe, e.mbyte});
            check({tag, " request hold"}, r.hold_bad, 0);
            if (e.mwe) check({tag, " mem_wdata"}, r.mwdata, e.mwdata);
        end
    endtask

    typedef struct {
        logic        st, byt, uns;
        logic [31:0] addr, wd;
        int          lat;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        int          exp_stalls, exp_fills, exp_reqs;
        logic [2:0]  exp_op;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        exp_t        e;
        logic [31:0] w;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 6, 1, 4, 3'b000, 32'h40};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, 3'b000, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h43, 32'h0, 0, 32'h0000_00DE, 1'b1, 0, 0, 0, 3'b110, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h41, 32'h55, 1, 32'h0, 1'b0, 2, 0, 2, 3'b011, 32'h41};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, 32'hDEAD_55EF, 1'b1, 0, 0, 0, 3'b000, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h1000, 32'h1234_5678, 0, 32'h0, 1'b0, 1, 0, 1, 3'b000,
                    32'h1000};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 0, 32'hFFFF_FFEF, 1'b1, 0, 0, 0, 3'b010, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, 32'hDEAD_55EF, 1'b1, 0, 0, 0, 3'b000, 32'h0};

        rst = 1'b1; req_i = 1'b0; store_i = 1'b0; byte_i = 1'b0; unsigned_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        n_cmp = 0; n_bad = 0;
        step(); step();
        rst = 1'b0;
        #2;
        check("reset stall", 32'(stall_o), 0);
        check("reset strobes", {cache_op_o, cache_fill_o, mem_req_o, mem_we_o, mem_byte_o}, 0);
        check("reset counters", {hit_cnt_o, miss_cnt_o}, 0);
        check("reset rdata/addr", rdata_o | mem_addr_o | mem_wdata_o | cache_wdata_o, 0);
        step();

        // Reset held for two cycles in the middle of a refill.
        req_i = 1'b1; addr_i = 32'h80;
        #2 check("miss stall", 32'(stall_o), 1);
        step();
        #2 check("refill req", 32'(mem_req_o), 1);
        check("refill addr", mem_addr_o, 32'h80);
        step();
        check("miss counted", 32'(miss_cnt_o), 1);
        rst = 1'b1; req_i = 1'b0;
        step();
        #2 check("req dropped by reset", 32'(mem_req_o), 0);
        step();
        rst = 1'b0;
        #2 check("post-reset stall", 32'(stall_o), 0);
        check("post-reset req", 32'(mem_req_o), 0);
        check("post-reset counters", {hit_cnt_o, miss_cnt_o}, 0);
        step();

        foreach (ref_res[i]) ref_res[i] = -1;
        ref_hits = 0; ref_misses = 0;
        env_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h40 >> 2] = 32'hDEAD_BEEF;

        foreach (vecs[i]) begin
            do_access(vecs[i].st, vecs[i].byt, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                      vecs[i].lat, r);
            e = ref_apply(vecs[i].st, vecs[i].byt, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                          vecs[i].lat);
            e.rdata  = vecs[i].exp_rdata;
            e.stalls = vecs[i].exp_stalls;
            e.fills  = vecs[i].exp_fills;
            e.reqs   = vecs[i].exp_reqs;
            e.op     = vecs[i].exp_op;
            e.maddr  = vecs[i].exp_maddr;
            compare($sformatf("vec%0d", i), r, e, vecs[i].chk_rdata);
        end
        check("vec hit_cnt", 32'(hit_cnt_o), 6);
        check("vec miss_cnt", 32'(miss_cnt_o), 1);

        // Stray ack while idle.
        mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5;
        #2 check("stray ack idle", {stall_o, mem_req_o, cache_fill_o}, 0);
        step();
        mem_ack_i = 1'b0;
        #2 check("after stray ack", {stall_o, mem_req_o, cache_fill_o}, 0);
        step();

        // Flush mid-refill: the fill still lands, the dropped load is never re-presented.
        req_i = 1'b1; store_i = 1'b0; addr_i = 32'h204;
        step();
        req_i = 1'b0;
        #2 check("flush refill req", 32'(mem_req_o), 1);
        step();
        mem_ack_i = 1'b1; mem_rdata_i = env_read(32'h204);
        step();
        mem_ack_i = 1'b0;
        #2 check("flush fill", 32'(cache_fill_o), 1);
        check("flush fill data", cache_wdata_o, ref_read(32'h204));
        step();
        #2 check("flush single fill", {cache_fill_o, stall_o}, 0);
        step();
        ref_misses++;
        ref_res[1] = int'(32'h204 >> 5);
        w = ref_read(32'h204);
        do_access(1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 0, r);
        e = ref_apply(1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 0);
        check("flushed line hits", 32'(r.stalls), 0);
        check("flushed line data", r.rdata, w);

        for (int i = 0; i < 200; i++) begin
            logic        st, byt, uns;
            logic [31:0] a, wd;
            int          lat;
            st  = ($urandom % 3) == 0;
            byt = 1'($urandom);
            uns = 1'($urandom);
            a   = {27'($urandom % 4), 3'($urandom), 2'b00};
            if (byt) a[1:0] = 2'($urandom);
            wd  = $urandom;
            lat = int'($urandom % 4);
            do_access(st, byt, uns, a, wd, lat, r);
            e = ref_apply(st, byt, uns, a, wd, lat);
            compare($sformatf("rnd%0d", i), r, e, !st);
            if ($urandom % 4 == 0) step();
        end

        check("final hit_cnt", 32'(hit_cnt_o), 32'(ref_hits % 65536));
        check("final miss_cnt", 32'(miss_cnt_o), 32'(ref_misses % 65536));
        check("wrap hit_cnt w2", 32'(hit_cnt2), 32'(ref_hits % 4));
        check("wrap miss_cnt w2", 32'(miss_cnt2), 32'(ref_misses % 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
